// File: rtl/msx_slot_router_if.sv
`default_nettype none
// ============================================================================
// Module   : msx_slot_router_if
// Purpose  : CPU-side, configuration and memory-side bus of the slot router.
// Revision : 1.0
// ============================================================================
interface msx_slot_router_if #(
    parameter int ADDR_W = 25
);
    localparam int PBASE_W = ADDR_W - 14;

    logic [15:0]        cpu_addr;
    logic [7:0]         cpu_dout;
    logic               cpu_rd;
    logic               cpu_wr;
    logic               cpu_mreq;
    logic               cpu_iorq;
    logic [7:0]         cpu_din;
    logic               cpu_din_en;
    logic               cpu_wait;
    logic               cfg_we;
    logic [5:0]         cfg_addr;
    logic [PBASE_W+1:0] cfg_data;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic               mem_wr;
    logic [7:0]         mem_din;
    logic [7:0]         mem_dout;
    logic               mem_ready;
    logic [1:0]         active_slot;
    logic [1:0]         active_subslot;
    logic               timeout_err;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rd, cpu_wr, cpu_mreq, cpu_iorq,
        input  cfg_we, cfg_addr, cfg_data, mem_dout, mem_ready,
        output cpu_din, cpu_din_en, cpu_wait, mem_addr, mem_rd, mem_wr, mem_din,
        output active_slot, active_subslot, timeout_err
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_rd, cpu_wr, cpu_mreq, cpu_iorq,
        output cfg_we, cfg_addr, cfg_data, mem_dout, mem_ready,
        input  cpu_din, cpu_din_en, cpu_wait, mem_addr, mem_rd, mem_wr, mem_din,
        input  active_slot, active_subslot, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/msx_slot_router.sv
`default_nettype none
// ============================================================================
// Module   : msx_slot_router
// Purpose  : Resolves Z80 memory cycles to slot/subslot/page, maps them through
//            a loadable page table and runs the wait-state memory handshake.
// Revision : 1.0
// ============================================================================
module msx_slot_router #(
    parameter int         NUM_SLOTS = 4,
    parameter logic [3:0] EXP_MASK  = 4'b1000,
    parameter int         ADDR_W    = 25,
    parameter int         TIMEOUT   = 255
) (
    input wire logic         clk,
    input wire logic         reset,
    msx_slot_router_if.slave bus
);
    localparam int         PBASE_W        = ADDR_W - 14;
    localparam logic [2:0] c_num_slots    = 3'(NUM_SLOTS);
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [7:0]         r_pslot;
    logic [7:0]         r_ss [0:3];
    logic [PBASE_W+1:0] r_tbl [0:63];
    logic               r_prev_access;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_din;
    logic [7:0]         r_data;
    logic [7:0]         r_cnt;
    logic               r_is_rd;
    logic               r_timeout_err;

    logic [1:0]         w_page, w_slot, w_subslot;
    logic               w_slot_ok, w_expanded;
    logic [PBASE_W+1:0] w_entry;
    logic               w_io_sel, w_io_rd, w_io_wr;
    logic               w_access, w_new, w_ss_hit, w_ss_rd, w_ss_wr, w_go_req;
    logic [7:0]         w_din;
    logic               w_din_en, w_wait;

    assign w_page     = bus.cpu_addr[15:14];
    assign w_slot     = r_pslot[{w_page, 1'b0} +: 2];
    assign w_slot_ok  = ({1'b0, w_slot} < c_num_slots);
    assign w_expanded = w_slot_ok & EXP_MASK[w_slot];
    assign w_subslot  = w_expanded ? r_ss[w_slot][{w_page, 1'b0} +: 2] : 2'b00;
    assign w_entry    = r_tbl[{w_slot, w_subslot, w_page}];

    // I/O wins over a simultaneous memory strobe.
    assign w_io_sel = bus.cpu_iorq & (bus.cpu_addr[7:0] == 8'hA8);
    assign w_io_rd  = w_io_sel & bus.cpu_rd;
    assign w_io_wr  = w_io_sel & bus.cpu_wr;
    assign w_access = bus.cpu_mreq & ~bus.cpu_iorq & (bus.cpu_rd | bus.cpu_wr);
    assign w_new    = w_access & ~r_prev_access & (r_state == S_IDLE);
    assign w_ss_hit = w_access & (r_state == S_IDLE) & (bus.cpu_addr == 16'hFFFF) & w_expanded;
    assign w_ss_rd  = w_ss_hit & ~bus.cpu_wr;
    assign w_ss_wr  = w_ss_hit & w_new & bus.cpu_wr;
    assign w_go_req = w_new & ~w_ss_hit & w_slot_ok & w_entry[PBASE_W+1]
                    & (~bus.cpu_wr | w_entry[PBASE_W]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_din    = r_data;
        w_din_en = 1'b0;
        w_wait   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wait = w_go_req;
                if (w_new && !w_ss_hit) w_next = w_go_req ? S_REQ : S_HOLD;
            end
            S_REQ: begin
                w_wait = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                w_wait = 1'b1;
                if (bus.mem_ready || (r_cnt == c_timeout_last)) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (!bus.cpu_mreq) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        if (w_io_rd) begin
            w_din    = r_pslot;
            w_din_en = 1'b1;
        end else if (w_ss_rd) begin
            w_din    = ~r_ss[w_slot];
            w_din_en = 1'b1;
        end else if (w_new && !w_go_req && !bus.cpu_wr) begin
            w_din    = 8'hFF;
            w_din_en = 1'b1;
        end else if (r_state == S_HOLD && r_is_rd) begin
            w_din_en = 1'b1;
        end
    end

    assign bus.cpu_din        = w_din;
    assign bus.cpu_din_en     = w_din_en;
    assign bus.cpu_wait       = w_wait;
    assign bus.mem_rd         = (r_state == S_REQ) & r_is_rd;
    assign bus.mem_wr         = (r_state == S_REQ) & ~r_is_rd;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_din        = r_mem_din;
    assign bus.active_slot    = w_slot;
    assign bus.active_subslot = w_subslot;
    assign bus.timeout_err    = r_timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pslot       <= 8'h00;
            r_prev_access <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= 8'h00;
            r_data        <= 8'hFF;
            r_cnt         <= 8'h00;
            r_is_rd       <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < 4; i++) r_ss[i] <= 8'h00;
        end else begin
            r_prev_access <= w_access;
            if (w_io_wr) r_pslot <= bus.cpu_dout;
            if (w_ss_wr) r_ss[w_slot] <= bus.cpu_dout;
            case (r_state)
                S_IDLE: begin
                    // Capture the translated request so later table writes cannot disturb it.
                    if (w_new && !w_ss_hit) begin
                        r_is_rd    <= ~bus.cpu_wr;
                        r_mem_addr <= {w_entry[PBASE_W-1:0], bus.cpu_addr[13:0]};
                        r_mem_din  <= bus.cpu_dout;
                        r_data     <= 8'hFF;
                    end
                end
                S_REQ: r_cnt <= 8'h00;
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        r_data <= bus.mem_dout;
                    end else if (r_cnt == c_timeout_last) begin
                        r_data        <= 8'hFF;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) r_tbl[i] <= '0;
        end else if (bus.cfg_we && ({1'b0, bus.cfg_addr[5:4]} < c_num_slots)) begin
            r_tbl[bus.cfg_addr] <= bus.cfg_data;
        end
    end
endmodule
`default_nettype wire
